// File: rtl/face_bbox.sv
`timescale 1ns/1ps
// face_bbox
//   Bounding-box extractor for a raster-order 1-bit skin mask. Tracks pixel
//   position with internal column/row counters, accumulates min/max column
//   and row of foreground pixels plus the foreground count, and publishes
//   one result per frame.
//
// Ports
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   in_de       pixel valid (one pixel per cycle when high)
//   in_data     mask pixel, 1 = foreground
//   sync_clr    synchronous resync: clears position and accumulators
//   out_valid   one-cycle pulse, new result on the outputs
//   bbox_found  frame foreground count >= MIN_PIX
//   x_min/x_max box column bounds (0 when no box)
//   y_min/y_max box row bounds (0 when no box)
//   pix_cnt     foreground count of the last frame, saturating
//   frame_cnt   frames reported since reset, wrapping
module face_bbox #(
  parameter int unsigned U_COL   = 1280,
  parameter int unsigned U_ROW   = 720,
  parameter int unsigned MIN_PIX = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_de,
  input  logic        in_data,
  input  logic        sync_clr,
  output logic        out_valid,
  output logic        bbox_found,
  output logic [11:0] x_min,
  output logic [11:0] x_max,
  output logic [11:0] y_min,
  output logic [11:0] y_max,
  output logic [21:0] pix_cnt,
  output logic [7:0]  frame_cnt
);

  localparam logic [11:0] COL_LAST = 12'(U_COL - 1);
  localparam logic [11:0] ROW_LAST = 12'(U_ROW - 1);
  localparam logic [21:0] CNT_MAX  = '1;
  // One extra bit so thresholds up to 2^22 still compare sensibly.
  localparam logic [22:0] MIN_W    = 23'(MIN_PIX);

  typedef enum logic [0:0] {SCAN, REPORT} state_t;

  state_t      state_reg, state_next;
  logic [11:0] col_reg, row_reg;
  logic [11:0] acc_xmin_reg, acc_xmax_reg, acc_ymin_reg, acc_ymax_reg;
  logic [21:0] acc_cnt_reg;

  logic        bbox_found_reg;
  logic [11:0] x_min_reg, x_max_reg, y_min_reg, y_max_reg;
  logic [21:0] pix_cnt_reg;
  logic [7:0]  frame_cnt_reg;

  logic        take;       // pixel accepted this cycle
  logic        last_pix;   // position counters sit on the final pixel
  logic        frame_end;  // final pixel accepted this cycle
  logic        found;
  logic [11:0] m_xmin, m_xmax, m_ymin, m_ymax;
  logic [21:0] m_cnt;

  assign take      = in_de && !sync_clr;
  assign last_pix  = (col_reg == COL_LAST) && (row_reg == ROW_LAST);
  assign frame_end = take && last_pix;

  // Accumulators merged with the current pixel. Used both for normal
  // accumulation and for the final merge at the end of a frame.
  always_comb begin
    m_xmin = acc_xmin_reg;
    m_xmax = acc_xmax_reg;
    m_ymin = acc_ymin_reg;
    m_ymax = acc_ymax_reg;
    m_cnt  = acc_cnt_reg;
    if (in_data) begin
      if (col_reg < acc_xmin_reg) m_xmin = col_reg;
      if (col_reg > acc_xmax_reg) m_xmax = col_reg;
      if (row_reg < acc_ymin_reg) m_ymin = row_reg;
      if (row_reg > acc_ymax_reg) m_ymax = row_reg;
      if (acc_cnt_reg != CNT_MAX) m_cnt = acc_cnt_reg + 22'd1;
    end
  end

  assign found = ({1'b0, m_cnt} >= MIN_W);

  // Position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (sync_clr) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (in_de) begin
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_LAST) ? 12'd0 : row_reg + 12'd1;
      end else begin
        col_reg <= col_reg + 12'd1;
      end
    end
  end

  // Accumulators; restart on the frame's last pixel so a pixel arriving
  // in the report cycle belongs cleanly to the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_xmin_reg <= '1;
      acc_xmax_reg <= '0;
      acc_ymin_reg <= '1;
      acc_ymax_reg <= '0;
      acc_cnt_reg  <= '0;
    end else if (sync_clr || frame_end) begin
      acc_xmin_reg <= '1;
      acc_xmax_reg <= '0;
      acc_ymin_reg <= '1;
      acc_ymax_reg <= '0;
      acc_cnt_reg  <= '0;
    end else if (take) begin
      acc_xmin_reg <= m_xmin;
      acc_xmax_reg <= m_xmax;
      acc_ymin_reg <= m_ymin;
      acc_ymax_reg <= m_ymax;
      acc_cnt_reg  <= m_cnt;
    end
  end

  // Result registers, loaded only at frame end and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bbox_found_reg <= 1'b0;
      x_min_reg      <= '0;
      x_max_reg      <= '0;
      y_min_reg      <= '0;
      y_max_reg      <= '0;
      pix_cnt_reg    <= '0;
      frame_cnt_reg  <= '0;
    end else if (frame_end) begin
      bbox_found_reg <= found;
      x_min_reg      <= found ? m_xmin : 12'd0;
      x_max_reg      <= found ? m_xmax : 12'd0;
      y_min_reg      <= found ? m_ymin : 12'd0;
      y_max_reg      <= found ? m_ymax : 12'd0;
      pix_cnt_reg    <= m_cnt;
      frame_cnt_reg  <= frame_cnt_reg + 8'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= SCAN;
    else        state_reg <= state_next;
  end

  // FSM next state / outputs. frame_end already excludes sync_clr, so a
  // clear always lands in SCAN.
  always_comb begin
    state_next = SCAN;
    out_valid  = 1'b0;
    case (state_reg)
      SCAN: begin
        if (frame_end) state_next = REPORT;
      end
      REPORT: begin
        out_valid  = 1'b1;
        state_next = SCAN;
      end
      default: state_next = SCAN;
    endcase
  end

  assign bbox_found = bbox_found_reg;
  assign x_min      = x_min_reg;
  assign x_max      = x_max_reg;
  assign y_min      = y_min_reg;
  assign y_max      = y_max_reg;
  assign pix_cnt    = pix_cnt_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_face_bbox.sv
`timescale 1ns/1ps
// Testbench for face_bbox: two instances (MIN_PIX=1 and MIN_PIX=4) share
// one 8x6 pixel stream; a frame-level reference model predicts each report.
module tb_face_bbox;

  localparam int NC = 8;
  localparam int NR = 6;
  localparam int NP = NC * NR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_de = 1'b0;
  logic in_data = 1'b0;
  logic sync_clr = 1'b0;

  logic        ov  [2];
  logic        bf  [2];
  logic [11:0] xmn [2];
  logic [11:0] xmx [2];
  logic [11:0] ymn [2];
  logic [11:0] ymx [2];
  logic [21:0] pc  [2];
  logic [7:0]  fc  [2];

  int thr [2] = '{1, 4};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      face_bbox #(
        .U_COL  (NC),
        .U_ROW  (NR),
        .MIN_PIX(gi == 0 ? 1 : 4)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_de     (in_de),
        .in_data   (in_data),
        .sync_clr  (sync_clr),
        .out_valid (ov[gi]),
        .bbox_found(bf[gi]),
        .x_min     (xmn[gi]),
        .x_max     (xmx[gi]),
        .y_min     (ymn[gi]),
        .y_max     (ymx[gi]),
        .pix_cnt   (pc[gi]),
        .frame_cnt (fc[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int xmin, xmax, ymin, ymax, cnt, frame, cyc;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  int exp_frame = 0;

  task automatic check(input string tag, input int got, input int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  // Reference: bounding box and count of a whole frame image.
  function automatic exp_t model(input logic [NP-1:0] img);
    exp_t e;
    e.xmin = 4095; e.xmax = 0; e.ymin = 4095; e.ymax = 0; e.cnt = 0;
    e.frame = 0; e.cyc = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (img[r*NC + c]) begin
          e.cnt++;
          if (c < e.xmin) e.xmin = c;
          if (c > e.xmax) e.xmax = c;
          if (r < e.ymin) e.ymin = r;
          if (r > e.ymax) e.ymax = r;
        end
    return e;
  endfunction

  // Report monitor: every report must land exactly one cycle after the
  // frame's last accepted pixel; any other out_valid is unexpected.
  always @(negedge clk) begin
    exp_t e;
    bit   f;
    if (rst_n && q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      for (int k = 0; k < 2; k++) begin
        f = (e.cnt >= thr[k]);
        check($sformatf("valid%0d", k), int'(ov[k]), 1);
        check($sformatf("found%0d", k), int'(bf[k]), int'(f));
        check($sformatf("x_min%0d", k), int'(xmn[k]), f ? e.xmin : 0);
        check($sformatf("x_max%0d", k), int'(xmx[k]), f ? e.xmax : 0);
        check($sformatf("y_min%0d", k), int'(ymn[k]), f ? e.ymin : 0);
        check($sformatf("y_max%0d", k), int'(ymx[k]), f ? e.ymax : 0);
        check($sformatf("pix_cnt%0d", k), int'(pc[k]), e.cnt);
        check($sformatf("frame_cnt%0d", k), int'(fc[k]), e.frame);
      end
      $display("[TB] report frame %0d: cnt=%0d box x=%0d..%0d y=%0d..%0d", e.frame, e.cnt,
               xmn[0], xmx[0], ymn[0], ymx[0]);
    end else begin
      for (int k = 0; k < 2; k++)
        if (ov[k] !== 1'b0) check($sformatf("spurious_valid%0d", k), int'(ov[k]), 0);
    end
  end

  task automatic tick(input logic de, input logic d, input logic clr);
    in_de = de;
    in_data = d;
    sync_clr = clr;
    @(posedge clk);
    #1;
    in_de = 1'b0;
    sync_clr = 1'b0;
  endtask

  // Stream npix pixels of img with random idle gaps (gap percent).
  task automatic send(input logic [NP-1:0] img, input int gap, input int npix);
    exp_t e;
    for (int p = 0; p < npix; p++) begin
      while (int'($urandom_range(99)) < gap) tick(1'b0, 1'($urandom), 1'b0);
      tick(1'b1, img[p], 1'b0);
      if (p == NP - 1) begin
        e = model(img);
        exp_frame = (exp_frame + 1) % 256;
        e.frame = exp_frame;
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    exp_frame = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_valid%0d", k), int'(ov[k]), 0);
      check($sformatf("rst_found%0d", k), int'(bf[k]), 0);
      check($sformatf("rst_x_min%0d", k), int'(xmn[k]), 0);
      check($sformatf("rst_x_max%0d", k), int'(xmx[k]), 0);
      check($sformatf("rst_y_min%0d", k), int'(ymn[k]), 0);
      check($sformatf("rst_y_max%0d", k), int'(ymx[k]), 0);
      check($sformatf("rst_pix_cnt%0d", k), int'(pc[k]), 0);
      check($sformatf("rst_frame_cnt%0d", k), int'(fc[k]), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [NP-1:0] rect_img();
    logic [NP-1:0] img = '0;
    for (int r = 1; r <= 3; r++)
      for (int c = 2; c <= 5; c++) img[r*NC + c] = 1'b1;
    return img;
  endfunction

  function automatic logic [NP-1:0] rand_img(input int dens);
    logic [NP-1:0] img = '0;
    for (int p = 0; p < NP; p++) img[p] = (int'($urandom_range(99)) < dens);
    return img;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [NP-1:0] img;
    in_de = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // A dense frame to put non-zero values on the outputs.
    send(rand_img(50), 30, NP);
    repeat (3) tick(1'b0, 1'b0, 1'b0);

    // Partial frame abandoned by reset; outputs must return to zero.
    send(rand_img(60), 20, 20);
    do_reset();

    // Empty frame
    send('0, 20, NP);
    // Rectangle with random gaps
    send(rect_img(), 40, NP);
    // Threshold: (1,1), (6,2), (3,4)
    img = '0;
    img[1*NC + 1] = 1'b1;
    img[2*NC + 6] = 1'b1;
    img[4*NC + 3] = 1'b1;
    send(img, 25, NP);
    repeat (2) tick(1'b0, 1'b0, 1'b0);

    // Back-to-back: B's first pixel lands in A's report cycle
    send(rect_img(), 0, NP);
    img = '0;
    img[NP-1] = 1'b1;
    send(img, 0, NP);
    repeat (2) tick(1'b0, 1'b0, 1'b0);

    // sync_clr at pixel 20 with a foreground pixel that must be dropped
    send(rand_img(50), 0, 20);
    tick(1'b1, 1'b1, 1'b1);
    img = '0;
    img[0] = 1'b1;
    send(img, 0, NP);
    repeat (2) tick(1'b0, 1'b0, 1'b0);

    // Randomized frames of varying density and gap rate
    for (int i = 0; i < 8; i++) send(rand_img($urandom_range(0, 30)), $urandom_range(0, 50), NP);

    repeat (4) tick(1'b0, 1'b0, 1'b0);
    check("pending_reports", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/face_bbox.md
# face_bbox

Stream-level bounding-box extractor placed directly downstream of the 3x3 erosion stage in the face detection pipeline. It consumes the cleaned 1-bit skin mask as a raster-order pixel stream qualified by `in_de` and tracks pixel position with internal column/row counters. It accumulates the min/max column and row of all foreground pixels and the foreground pixel count, and reports one result per frame to the face-box overlay logic.

## Interface
Parameters:
- `U_COL`, 1280: active pixels per line (2..4095)
- `U_ROW`, 720: active lines per frame (2..4095)
- `MIN_PIX`, 256: minimum foreground count for a valid box

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_de`  in  1  pixel valid; one pixel per cycle when high, gaps allowed anywhere
- `in_data`  in  1  mask pixel, 1 = foreground
- `sync_clr`  in  1  synchronous frame resync; clears position counters and accumulators
- `out_valid`  out  1  one-cycle pulse: new result on outputs
- `bbox_found`  out  1  1 when frame foreground count >= `MIN_PIX`
- `x_min`, `x_max`  out  12  box column bounds
- `y_min`, `y_max`  out  12  box row bounds
- `pix_cnt`  out  22  foreground pixel count of last frame, saturating
- `frame_cnt`  out  8  frames reported since reset, wraps 255 -> 0

## Operation
- Position: `col` (12b) increments on each `in_de` cycle. At `U_COL-1` it wraps to 0 and `row` increments. At the last pixel (`col=U_COL-1`, `row=U_ROW-1`) both return to 0.
- Accumulator reset values: `acc_xmin=acc_ymin=4095`, `acc_xmax=acc_ymax=0`, `acc_cnt=0`.
- On `in_de && in_data`:
  - `acc_xmin=min(acc_xmin,col)`, `acc_xmax=max(acc_xmax,col)`, same for rows.
  - `acc_cnt+1`, saturating at 2^22-1.
- FSM with two states:
  - SCAN: accumulating.
  - REPORT: entered on the edge that samples the last pixel; lasts exactly one cycle; returns to SCAN unconditionally.
- On entry to REPORT:
  - Output registers load the accumulator values merged with the last pixel's contribution.
  - The accumulators load their reset values on that same edge.
  - A pixel presented during the REPORT cycle is the first pixel (0,0) of the next frame and is accumulated normally. Back-to-back frames lose nothing.
- Result gating:
  - If merged count >= `MIN_PIX`: `bbox_found=1` and coordinates are the merged values.
  - Otherwise: `bbox_found=0` and all four coordinates are 0.
  - `pix_cnt` always reports the true merged count.
- `frame_cnt` increments on entry to REPORT.
- `sync_clr` has priority over `in_de`:
  - Clears col, row and accumulators, and forces SCAN.
  - A pixel presented in the same cycle is discarded.
  - The next `in_de` pixel is (0,0).
  - Result outputs and `frame_cnt` are unchanged; no `out_valid`.
- Outputs hold their values between reports.

## Timing
- Reset values:
  - `out_valid=0`, `bbox_found=0`, `x_min=x_max=y_min=y_max=0`, `pix_cnt=0`, `frame_cnt=0`.
  - Internally: col=row=0, accumulators at reset values, FSM in SCAN.
- Latency: results are registered on the clock edge that samples the last pixel with `in_de=1`. `out_valid` is high for exactly the following cycle.
- No stall input: the block accepts one pixel every cycle.
- `in_de` low cycles freeze the counters and accumulators.
- Reset mid-frame abandons the partial frame. No report is generated and the next pixel after release is (0,0).
- Min/max compare and count use the 12-bit and 22-bit unsigned widths above.

## Test plan
Use `U_COL=8`, `U_ROW=6` for all scenarios.
- Reset check: assert `rst_n` low mid-stream, then release. All outputs read 0 and the next frame reports from (0,0).
- Empty frame, `MIN_PIX=1`: 48 pixels with `in_data=0`. Expect `out_valid` pulse, `bbox_found=0`, coordinates 0, `pix_cnt=0`, `frame_cnt=1`.
- Rectangle, `MIN_PIX=1`: cols 2..5 × rows 1..3 foreground, random `in_de` gaps. Expect `x_min=2`, `x_max=5`, `y_min=1`, `y_max=3`, `pix_cnt=12`, `bbox_found=1`.
- Threshold, `MIN_PIX=4`: 3 foreground pixels at (1,1), (6,2), (3,4). Expect `bbox_found=0`, coordinates 0, `pix_cnt=3`.
- Back-to-back frames, `MIN_PIX=1`, continuous `in_de`:
  - Frame A: the rectangle above, reported as in the rectangle scenario.
  - Frame B: only the last pixel (7,5) foreground, with its first pixel presented during A's REPORT cycle.
  - Expect B's report `x=7..7`, `y=5..5`, `pix_cnt=1`, `frame_cnt=2`.
- sync_clr: pulse `sync_clr` with `in_de=1` at pixel 20 of a frame, then send a full 48-pixel frame with foreground at (0,0) only. Expect no report at the old frame position; one report with `x=0..0`, `y=0..0`, `pix_cnt=1`; `frame_cnt` not incremented by the clear.
